// File: rtl/dmem_rmw_ctrl_pkg.sv
// Shared definitions for the data-memory RMW front end.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package dmem_rmw_ctrl_pkg;

  // Controller states; one transaction in flight at a time.
  typedef enum logic [2:0] {
    DMEM_IDLE,
    DMEM_RD,
    DMEM_RMW_RD,
    DMEM_RMW_WR,
    DMEM_RSP
  } dmem_state_e;

  localparam logic [3:0] DMEM_STRB_FULL = 4'hF;
  localparam logic [3:0] DMEM_STRB_NONE = 4'h0;

  // Expand 4 byte enables into a 32-bit lane mask.
  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/dmem_rmw_ctrl_if.sv
// LSU request/response channel plus SRAM port of the RMW front end.
// Latency: n/a (wiring only).
// Backpressure: req valid/ready, rsp valid/ready; SRAM side has none.
// Ports: req_* (LSU request), rsp_* (LSU response), mem_* (sram16kx32 port).
// slave = controller side, master = LSU + SRAM side.
interface dmem_rmw_ctrl_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_wen_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_strb_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        mem_en_o;
  logic        mem_wen_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, req_wen_i, req_addr_i, req_wdata_i, req_strb_i,
    output req_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  rsp_ready_i,
    output mem_en_o, mem_wen_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output req_valid_i, req_wen_i, req_addr_i, req_wdata_i, req_strb_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output rsp_ready_i,
    input  mem_en_o, mem_wen_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/dmem_byte_merge.sv
// Byte-lane merge of new store data over an old SRAM word.
// Latency: combinational.
// Backpressure: none.
// Ports: old_word (SRAM read data), new_word (store data), strb (lanes taken
// from new_word), merged (result).
module dmem_byte_merge
  import dmem_rmw_ctrl_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  strb,
  output logic [31:0] merged
);

  logic [31:0] mask;

  assign mask   = strb_to_mask(strb);
  assign merged = (new_word & mask) | (old_word & ~mask);

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// Data-memory front end: loads/full stores pass through, partial stores run as RMW.
// Latency: err/full/empty store rsp T+1, load rsp T+2, partial store rsp T+3.
// Backpressure: one transaction outstanding; req_ready only in IDLE, rsp held until rsp_ready.
// Ports: clk_i, rst_n_i (sync, active-low), bus (dmem_rmw_ctrl_if.slave).
module dmem_rmw_ctrl
  import dmem_rmw_ctrl_pkg::*;
#(
  parameter int          MEM_AW    = 14,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  dmem_rmw_ctrl_if.slave bus
);

  localparam int WIN_LSB = MEM_AW + 2;

  dmem_state_e state_q, state_d;

  logic [31:2] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;
  logic [31:0] merged_q;
  logic [31:0] merged_w;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic        in_win;
  logic        accept;
  logic        mem_en_c;
  logic        mem_wen_c;
  logic [31:0] mem_addr_c;
  logic [31:0] mem_wdata_c;
  logic        unused_addr_lsb;

  // Byte offset bits carry no meaning for a word-wide SRAM.
  assign unused_addr_lsb = ^bus.req_addr_i[1:0];

  assign in_win = (bus.req_addr_i[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
  assign accept = rst_n_i && (state_q == DMEM_IDLE) && bus.req_valid_i;

  // Old word arrives one cycle after the RMW read; new bytes come from the latch.
  dmem_byte_merge u_merge (
    .old_word (bus.mem_rdata_i),
    .new_word (wdata_q),
    .strb     (strb_q),
    .merged   (merged_w)
  );

  always_comb begin
    state_d     = state_q;
    mem_en_c    = 1'b0;
    mem_wen_c   = 1'b0;
    mem_addr_c  = {addr_q, 2'b00};
    mem_wdata_c = wdata_q;
    unique case (state_q)
      DMEM_IDLE: begin
        // First SRAM access goes out in the accept cycle, straight from req_*.
        mem_addr_c  = {bus.req_addr_i[31:2], 2'b00};
        mem_wdata_c = bus.req_wdata_i;
        if (bus.req_valid_i) begin
          if (!in_win) begin
            state_d = DMEM_RSP;
          end else if (!bus.req_wen_i) begin
            mem_en_c = 1'b1;
            state_d  = DMEM_RD;
          end else if (bus.req_strb_i == DMEM_STRB_FULL) begin
            mem_en_c  = 1'b1;
            mem_wen_c = 1'b1;
            state_d   = DMEM_RSP;
          end else if (bus.req_strb_i == DMEM_STRB_NONE) begin
            state_d = DMEM_RSP;
          end else begin
            mem_en_c = 1'b1;
            state_d  = DMEM_RMW_RD;
          end
        end
      end
      DMEM_RD:     state_d = DMEM_RSP;
      DMEM_RMW_RD: state_d = DMEM_RMW_WR;
      DMEM_RMW_WR: begin
        mem_en_c    = 1'b1;
        mem_wen_c   = 1'b1;
        mem_wdata_c = merged_q;
        state_d     = DMEM_RSP;
      end
      DMEM_RSP: begin
        if (bus.rsp_ready_i) state_d = DMEM_IDLE;
      end
      default: state_d = DMEM_IDLE;
    endcase
    // Reset must silence the SRAM port even mid-RMW.
    if (!rst_n_i) begin
      mem_en_c  = 1'b0;
      mem_wen_c = 1'b0;
      state_d   = DMEM_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= DMEM_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      merged_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q      <= bus.req_addr_i[31:2];
        wdata_q     <= bus.req_wdata_i;
        strb_q      <= bus.req_strb_i;
        rsp_rdata_q <= '0;
        rsp_err_q   <= !in_win;
      end
      if (state_q == DMEM_RD)     rsp_rdata_q <= bus.mem_rdata_i;
      if (state_q == DMEM_RMW_RD) merged_q    <= merged_w;
    end
  end

  assign bus.req_ready_o = rst_n_i && (state_q == DMEM_IDLE);
  assign bus.rsp_valid_o = (state_q == DMEM_RSP);
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.mem_en_o    = mem_en_c;
  assign bus.mem_wen_o   = mem_wen_c;
  assign bus.mem_addr_o  = mem_addr_c;
  assign bus.mem_wdata_o = mem_wdata_c;

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Bench for dmem_rmw_ctrl with a behavioural sram16kx32 and a word-array reference memory.
// Latency: n/a.
// Backpressure: random rsp_ready stalls.
module tb_dmem_rmw_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_rmw_ctrl_if bus();

  dmem_rmw_ctrl #(.MEM_AW(14), .BASE_ADDR(32'h0000_0000)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int en_cnt = 0;
  int wen_cnt = 0;
  int last_wen_cyc = -1;
  int hs_cnt = 0;

  // Behavioural SRAM: synchronous write, registered read data.
  logic [31:0] sram [0:16383];
  logic [31:0] sram_q = 32'h0;
  assign bus.mem_rdata_i = sram_q;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_en_o) begin
      if (bus.mem_wen_o) sram[bus.mem_addr_o[15:2]] <= bus.mem_wdata_o;
      else               sram_q <= sram[bus.mem_addr_o[15:2]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input logic wen, input logic [31:0] addr, input logic [3:0] strb);
    if (addr[31:16] != 16'h0) return 1;
    if (!wen) return 2;
    if (strb == 4'hF || strb == 4'h0) return 1;
    return 3;
  endfunction

  // Reference model: word memory updated when a store's response is taken.
  logic [31:0] ref_mem [int];
  logic        p_vld = 1'b0;
  logic        p_wen;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_strb;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_rdata;
  logic        prev_err;
  logic [31:0] m_word, e_rd;
  logic        e_err;
  int          m_idx;

  always @(negedge clk) begin
    if (bus.mem_en_o) en_cnt++;
    if (bus.mem_en_o && bus.mem_wen_o) begin
      wen_cnt++;
      last_wen_cyc = cyc;
    end
    if (!rst_n) begin
      check("reset_req_ready", {31'h0, bus.req_ready_o}, 32'h0);
      check("reset_mem_en", {30'h0, bus.mem_en_o, bus.mem_wen_o}, 32'h0);
      p_vld     = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (bus.rsp_valid_o) begin
        if (!p_vld) check("rsp_without_req", {31'h0, bus.rsp_valid_o}, {31'h0, p_vld});
        if (prev_hold) begin
          check("rsp_stable_rdata", bus.rsp_rdata_o, prev_rdata);
          check("rsp_stable_err", {31'h0, bus.rsp_err_o}, {31'h0, prev_err});
        end
        if (bus.rsp_ready_i && p_vld) begin
          m_idx = int'(p_addr[15:2]);
          if ((p_addr >> 16) != 32'h0) begin
            e_err = 1'b1;
            e_rd  = 32'h0;
          end else if (!p_wen) begin
            e_err = 1'b0;
            e_rd  = ref_mem.exists(m_idx) ? ref_mem[m_idx] : 32'h0;
          end else begin
            e_err  = 1'b0;
            e_rd   = 32'h0;
            m_word = ref_mem.exists(m_idx) ? ref_mem[m_idx] : 32'h0;
            for (int k = 0; k < 4; k++)
              if (p_strb[k]) m_word[8*k +: 8] = p_wdata[8*k +: 8];
            ref_mem[m_idx] = m_word;
          end
          check("rsp_rdata", bus.rsp_rdata_o, e_rd);
          check("rsp_err", {31'h0, bus.rsp_err_o}, {31'h0, e_err});
          hs_cnt++;
          p_vld     = 1'b0;
          prev_hold = 1'b0;
        end else begin
          prev_hold  = 1'b1;
          prev_rdata = bus.rsp_rdata_o;
          prev_err   = bus.rsp_err_o;
        end
      end else begin
        if (prev_hold) check("rsp_dropped", {31'h0, bus.rsp_valid_o}, 32'h1);
        prev_hold = 1'b0;
      end
      if (bus.req_valid_i && bus.req_ready_o) begin
        p_vld   = 1'b1;
        p_wen   = bus.req_wen_i;
        p_addr  = bus.req_addr_i;
        p_wdata = bus.req_wdata_i;
        p_strb  = bus.req_strb_i;
      end
    end
  end

  // One full transaction: request, wait response, hold for 'stall' cycles, handshake.
  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int stall,
                       output int acc, output int lat, output logic [31:0] rdata, output logic err);
    int n;
    acc = -1; lat = -1; rdata = 32'h0; err = 1'b0;
    tick();
    bus.req_valid_i = 1'b1;
    bus.req_wen_i   = wen;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    bus.req_strb_i  = strb;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready_o) begin
      check("accept_timeout", {31'h0, bus.req_ready_o}, 32'h1);
      bus.req_valid_i = 1'b0;
      return;
    end
    acc = cyc;
    tick();
    // Scramble the request bus: the controller must work from its latches.
    bus.req_valid_i = 1'b0;
    bus.req_wen_i   = 1'($urandom);
    bus.req_addr_i  = $urandom;
    bus.req_wdata_i = $urandom;
    bus.req_strb_i  = 4'($urandom);
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rsp_valid_o) begin
      check("rsp_timeout", {31'h0, bus.rsp_valid_o}, 32'h1);
      return;
    end
    lat   = cyc - acc;
    rdata = bus.rsp_rdata_o;
    err   = bus.rsp_err_o;
    check("rsp_latency", 32'(lat), 32'(exp_lat(wen, addr, strb)));
    repeat (stall) begin
      @(negedge clk);
      check("hold_valid", {31'h0, bus.rsp_valid_o}, 32'h1);
      check("hold_rdata", bus.rsp_rdata_o, rdata);
      check("hold_req_ready", {31'h0, bus.req_ready_o}, 32'h0);
    end
    tick();
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  int          acc, lat, w0, e0, h0;
  logic [31:0] rd;
  logic        er;
  logic        r_wen;
  logic [31:0] r_addr;
  logic [3:0]  r_strb;

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_wen_i   = 1'b0;
    bus.req_addr_i  = 32'h0;
    bus.req_wdata_i = 32'h0;
    bus.req_strb_i  = 4'h0;
    bus.rsp_ready_i = 1'b0;

    // 1. reset
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_rsp_valid", {31'h0, bus.rsp_valid_o}, 32'h0);
    check("post_reset_req_ready", {31'h0, bus.req_ready_o}, 32'h1);
    check("post_reset_no_mem_en", 32'(en_cnt), 32'h0);

    // 2. full store then load
    w0 = wen_cnt;
    issue(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 0, acc, lat, rd, er);
    check("t2_store_lat", 32'(lat), 32'd1);
    check("t2_store_wen", 32'(wen_cnt - w0), 32'd1);
    issue(1'b0, 32'h100, 32'h0, 4'h0, 0, acc, lat, rd, er);
    check("t2_load_lat", 32'(lat), 32'd2);
    check("t2_load_rdata", rd, 32'hDEADBEEF);
    check("t2_load_err", {31'h0, er}, 32'h0);

    // 3. partial store read-modify-write
    issue(1'b1, 32'h200, 32'h11223344, 4'hF, 0, acc, lat, rd, er);
    w0 = wen_cnt;
    issue(1'b1, 32'h200, 32'h0000AB00, 4'b0010, 0, acc, lat, rd, er);
    check("t3_rmw_lat", 32'(lat), 32'd3);
    check("t3_rmw_wen_once", 32'(wen_cnt - w0), 32'd1);
    check("t3_rmw_wen_cycle", 32'(last_wen_cyc - acc), 32'd2);
    issue(1'b0, 32'h200, 32'h0, 4'h0, 0, acc, lat, rd, er);
    check("t3_load_rdata", rd, 32'h1122AB44);

    // 4. empty-strobe store
    e0 = en_cnt;
    issue(1'b1, 32'h200, 32'hFFFFFFFF, 4'h0, 0, acc, lat, rd, er);
    check("t4_no_mem_en", 32'(en_cnt - e0), 32'd0);
    check("t4_ack_lat", 32'(lat), 32'd1);
    issue(1'b0, 32'h200, 32'h0, 4'h0, 0, acc, lat, rd, er);
    check("t4_load_rdata", rd, 32'h1122AB44);

    // 5. out-of-window load
    e0 = en_cnt;
    issue(1'b0, 32'h0001_0000, 32'h0, 4'h0, 0, acc, lat, rd, er);
    check("t5_err", {31'h0, er}, 32'h1);
    check("t5_lat", 32'(lat), 32'd1);
    check("t5_rdata", rd, 32'h0);
    check("t5_no_mem_en", 32'(en_cnt - e0), 32'd0);

    // 6. response held for 5 cycles
    issue(1'b0, 32'h100, 32'h0, 4'h0, 5, acc, lat, rd, er);
    check("t6_rdata", rd, 32'hDEADBEEF);

    // reset while in RMW_RD abandons the partial store
    w0 = wen_cnt;
    h0 = hs_cnt;
    tick();
    bus.req_valid_i = 1'b1;
    bus.req_wen_i   = 1'b1;
    bus.req_addr_i  = 32'h100;
    bus.req_wdata_i = 32'h000000AA;
    bus.req_strb_i  = 4'b0001;
    @(negedge clk);
    check("rst_mid_accept_ready", {31'h0, bus.req_ready_o}, 32'h1);
    tick();
    bus.req_valid_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_mid_no_rsp", {31'h0, bus.rsp_valid_o}, 32'h0);
    end
    tick();
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst_mid_idle_no_rsp", {31'h0, bus.rsp_valid_o}, 32'h0);
    end
    check("rst_mid_no_wen", 32'(wen_cnt - w0), 32'd0);
    check("rst_mid_no_handshake", 32'(hs_cnt - h0), 32'd0);
    issue(1'b0, 32'h100, 32'h0, 4'h0, 0, acc, lat, rd, er);
    check("rst_mid_mem_intact", rd, 32'hDEADBEEF);

    // random mix over 16 words, initialised first
    for (int i = 0; i < 16; i++)
      issue(1'b1, 32'h400 + 32'(4 * i), $urandom, 4'hF, 0, acc, lat, rd, er);
    for (int i = 0; i < 1000; i++) begin
      r_wen = 1'($urandom);
      if ($urandom_range(0, 7) == 0)
        r_addr = {16'($urandom_range(1, 16'hFFFF)), 16'($urandom)};
      else
        r_addr = 32'h400 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       r_strb = 4'h0;
        1:       r_strb = 4'hF;
        default: r_strb = 4'($urandom);
      endcase
      issue(r_wen, r_addr, $urandom, r_strb, $urandom_range(0, 3), acc, lat, rd, er);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
